// File: rtl/axis_window_3x3_gen.sv
// 3x3 window generator: two-line buffer, edge replication, AXI-Stream in/out.
// Define AXIS_WIN3X3_GEOM_CHECK_EN to build the sticky err_geom checker.
module axis_window_3x3_gen #(
   parameter int FRAME_WIDTH  = 640,
   parameter int FRAME_HEIGHT = 480
) (
   input  logic         axis_aclk,
   input  logic         axis_aresetn,
   input  logic [15:0]  s_axis_tdata,
   input  logic         s_axis_tuser,
   input  logic         s_axis_tvalid,
   output logic         s_axis_tready,
   input  logic         s_axis_tlast,
   output logic [143:0] m_axis_tdata,
   output logic         m_axis_tuser,
   output logic         m_axis_tvalid,
   input  logic         m_axis_tready,
   output logic         m_axis_tlast,
   output logic         err_geom
);
   localparam int XW = $clog2(FRAME_WIDTH + 1);
   localparam int YW = $clog2(FRAME_HEIGHT + 1);
   localparam int AW = $clog2(FRAME_WIDTH);
   localparam logic [XW-1:0] XLAST = XW'(FRAME_WIDTH - 1);
   localparam logic [XW-1:0] XEND  = XW'(FRAME_WIDTH);
   localparam logic [YW-1:0] YLAST = YW'(FRAME_HEIGHT - 1);

   typedef enum logic [2:0] {IDLE, FIRST, RUN, EOL, FLUSH} state_t;

   state_t         state_q, state_d;
   logic [XW-1:0]  x_q, x_d;
   logic [YW-1:0]  y_q, y_d;
   logic [47:0]    lc_q, lc_d, cc_q, cc_d;
   logic [143:0]   tdata_q, tdata_d;
   logic           tvalid_q, tvalid_d;
   logic           tuser_q, tuser_d;
   logic           tlast_q, tlast_d;
   logic           rdy_q;
   logic [31:0]    mem [FRAME_WIDTH];
   logic [31:0]    rd_q;
   logic [AW-1:0]  rd_addr, wr_addr;
   logic [31:0]    wr_data;
   logic           wr_en;
   logic [47:0]    col_n;
   logic           out_free, acc, step;

   // columns are {top, mid, bot}; slots run bot..top, left..right
   function automatic logic [143:0] win(input logic [47:0] l, c, r);
      return {r[47:32], c[47:32], l[47:32],
              r[31:16], c[31:16], l[31:16],
              r[15:0],  c[15:0],  l[15:0]};
   endfunction

   assign out_free      = !tvalid_q || m_axis_tready;
   assign s_axis_tready = rdy_q && out_free;
   assign acc           = s_axis_tvalid && s_axis_tready;
   assign step          = acc || (!rdy_q && out_free &&
                          (state_q == EOL || state_q == FLUSH));

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      lc_d     = lc_q;
      cc_d     = cc_q;
      tdata_d  = tdata_q;
      tuser_d  = tuser_q;
      tlast_d  = tlast_q;
      tvalid_d = tvalid_q && !m_axis_tready;
      wr_en    = 1'b0;
      wr_addr  = x_q[AW-1:0];
      wr_data  = {rd_q[15:0], s_axis_tdata};
      col_n    = {rd_q[31:16], rd_q[15:0], s_axis_tdata};
      if (y_q == YW'(1)) col_n[47:32] = rd_q[15:0];
      if (state_q == FLUSH) col_n[15:0] = rd_q[15:0];
      if (step) begin
         unique case (state_q)
            IDLE: begin
               if (s_axis_tuser) begin
                  wr_en   = 1'b1;
                  wr_addr = '0;
                  x_d     = XW'(1);
                  y_d     = '0;
                  state_d = FIRST;
               end
            end
            FIRST, RUN: begin
               if (s_axis_tuser) begin
                  wr_en   = 1'b1;
                  wr_addr = '0;
                  x_d     = XW'(1);
                  y_d     = '0;
                  state_d = FIRST;
               end else begin
                  wr_en = 1'b1;
                  if (state_q == RUN && x_q != '0) begin
                     tvalid_d = 1'b1;
                     tdata_d  = win(lc_q, cc_q, col_n);
                     tuser_d  = (y_q == YW'(1)) && (x_q == XW'(1));
                     tlast_d  = 1'b0;
                  end
                  lc_d = (x_q == '0) ? col_n : cc_q;
                  cc_d = col_n;
                  if (x_q == XLAST) begin
                     x_d     = '0;
                     state_d = EOL;
                  end else begin
                     x_d = x_q + XW'(1);
                  end
               end
            end
            EOL: begin
               if (y_q != '0) begin
                  tvalid_d = 1'b1;
                  tdata_d  = win(lc_q, cc_q, cc_q);
                  tuser_d  = 1'b0;
                  tlast_d  = 1'b1;
               end
               y_d     = y_q + YW'(1);
               state_d = (y_q == YLAST) ? FLUSH : RUN;
            end
            FLUSH: begin
               if (x_q == XEND) begin
                  tvalid_d = 1'b1;
                  tdata_d  = win(lc_q, cc_q, cc_q);
                  tuser_d  = 1'b0;
                  tlast_d  = 1'b1;
                  x_d      = '0;
                  y_d      = '0;
                  state_d  = IDLE;
               end else begin
                  if (x_q != '0) begin
                     tvalid_d = 1'b1;
                     tdata_d  = win(lc_q, cc_q, col_n);
                     tuser_d  = 1'b0;
                     tlast_d  = 1'b0;
                  end
                  lc_d = (x_q == '0) ? col_n : cc_q;
                  cc_d = col_n;
                  x_d  = x_q + XW'(1);
               end
            end
            default: ;
         endcase
      end
      rd_addr = (x_d == XEND) ? '0 : x_d[AW-1:0];
   end

   // read is prefetched for the column the next step will consume
   always_ff @(posedge axis_aclk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_q <= mem[rd_addr];
   end

   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         lc_q     <= '0;
         cc_q     <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tuser_q  <= 1'b0;
         tlast_q  <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         lc_q     <= lc_d;
         cc_q     <= cc_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tuser_q  <= tuser_d;
         tlast_q  <= tlast_d;
         rdy_q    <= (state_d == IDLE) || (state_d == FIRST) ||
                     (state_d == RUN);
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tuser  = tuser_q;
   assign m_axis_tlast  = tlast_q;

`ifdef AXIS_WIN3X3_GEOM_CHECK_EN
   logic err_q;
   logic in_frame, tl_bad;

   assign in_frame = s_axis_tuser || (state_q != IDLE);
   assign tl_bad   = s_axis_tuser ? s_axis_tlast
                                  : (s_axis_tlast != (x_q == XLAST));

   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         err_q <= 1'b0;
      end else if (acc && ((s_axis_tuser && state_q != IDLE) ||
                           (in_frame && tl_bad))) begin
         err_q <= 1'b1;
      end
   end

   assign err_geom = err_q;
`else
   logic unused_tlast;
   assign unused_tlast = s_axis_tlast;
   assign err_geom     = 1'b0;
`endif

endmodule

// File: tb/tb_axis_window_3x3_gen.sv
// Randomised self-checking bench for axis_window_3x3_gen (W=4, H=3)
// against a clamp-based window reference model.
module tb_axis_window_3x3_gen;
   localparam int W = 4;
   localparam int H = 3;

   typedef struct packed {
      logic [15:0] d;
      logic        u;
      logic        l;
   } pix_t;

   typedef struct packed {
      logic [143:0] d;
      logic         u;
      logic         l;
   } win_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [15:0]  s_data = '0;
   logic         s_user = 1'b0;
   logic         s_valid = 1'b0;
   logic         s_last = 1'b0;
   logic         s_ready;
   logic [143:0] m_data;
   logic         m_user, m_valid, m_last;
   logic         m_ready = 1'b1;
   logic         err;

   pix_t        in_q[$];
   win_t        exp_q[$];
   win_t        rx_q[$];
   logic [15:0] fr [H][W];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          stall_bad = 0;
   int          rdy_low = 0;
   bit          cnt_en = 1'b0;
   bit          toggle = 1'b0;
   bit          prev_stall = 1'b0;
   win_t        prev_w;

   axis_window_3x3_gen #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
      .axis_aclk(clk),
      .axis_aresetn(rst_n),
      .s_axis_tdata(s_data),
      .s_axis_tuser(s_user),
      .s_axis_tvalid(s_valid),
      .s_axis_tready(s_ready),
      .s_axis_tlast(s_last),
      .m_axis_tdata(m_data),
      .m_axis_tuser(m_user),
      .m_axis_tvalid(m_valid),
      .m_axis_tready(m_ready),
      .m_axis_tlast(m_last),
      .err_geom(err)
   );

   always #5 clk = ~clk;

   // monitor: collects accepted windows, stall stability, tready-low cycles
   always @(negedge clk) begin
      win_t w;
      w.d = m_data;
      w.u = m_user;
      w.l = m_last;
      if (rst_n) begin
         if (prev_stall && (!m_valid || w !== prev_w)) stall_bad++;
         prev_stall = m_valid && !m_ready;
         prev_w     = w;
         if (m_valid && m_ready) rx_q.push_back(w);
         if (cnt_en && !s_ready) rdy_low++;
      end else begin
         prev_stall = 1'b0;
      end
   end

   function automatic logic [15:0] px(int y, int x);
      int cy, cx;
      cy = (y < 0) ? 0 : ((y > H - 1) ? H - 1 : y);
      cx = (x < 0) ? 0 : ((x > W - 1) ? W - 1 : x);
      return fr[cy][cx];
   endfunction

   function automatic win_t ref_win(int y, int x);
      win_t w;
      int   k;
      k = 0;
      w.d = '0;
      for (int dy = 1; dy >= -1; dy--) begin
         for (int dx = -1; dx <= 1; dx++) begin
            w.d[16*k +: 16] = px(y + dy, x + dx);
            k++;
         end
      end
      w.u = (y == 0) && (x == 0);
      w.l = (x == W - 1);
      return w;
   endfunction

   task automatic make_frame(input int mode);
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            case (mode)
               0: fr[y][x] = 16'(16 * y + x);
               1: fr[y][x] = 16'($urandom);
               default: fr[y][x] = 16'h8000 | 16'(16 * y + x);
            endcase
   endtask

   task automatic queue_pixels(input int n);
      pix_t p;
      for (int i = 0; i < n; i++) begin
         p.d = fr[i / W][i % W];
         p.u = (i == 0);
         p.l = ((i % W) == W - 1);
         in_q.push_back(p);
      end
   endtask

   task automatic queue_exp_all();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            exp_q.push_back(ref_win(y, x));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (toggle) m_ready = ~m_ready;
   endtask

   task automatic play(input int budget, output int left);
      int t;
      bit fire;
      t = 0;
      while (in_q.size() > 0 && t < budget) begin
         s_valid = 1'b1;
         s_data  = in_q[0].d;
         s_user  = in_q[0].u;
         s_last  = in_q[0].l;
         @(negedge clk);
         fire = s_ready;
         tick();
         if (fire) void'(in_q.pop_front());
         t++;
      end
      s_valid = 1'b0;
      s_user  = 1'b0;
      s_last  = 1'b0;
      left    = in_q.size();
      in_q.delete();
   endtask

   task automatic wait_rx(input int n);
      int t;
      t = 0;
      while (rx_q.size() < n && t < 400) begin
         tick();
         t++;
      end
      repeat (20) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      m_ready = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (m_valid !== 1'b0 || m_user !== 1'b0 || m_last !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_ctl: valid/user/last=%b%b%b need 000",
                  m_valid, m_user, m_last);
      end
      n_cmp++;
      if (m_data !== '0) begin
         n_bad++;
         $display("FAIL reset_data: got %h need 0", m_data);
      end
      n_cmp++;
      if (s_ready !== 1'b0 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_rdy_err: got %b%b need 00", s_ready, err);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      n_cmp++;
      if (s_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL idle_ready: got %b need 1", s_ready);
      end
   endtask

   task automatic test_basic();
      int left;
      win_t g, e;
      make_frame(0);
      queue_pixels(W * H);
      queue_exp_all();
      rx_q.delete();
      play(200, left);
      wait_rx(W * H);
      n_cmp++;
      if (left != 0 || rx_q.size() != W * H) begin
         n_bad++;
         $display("FAIL basic_count: left %0d got %0d windows need 0/%0d",
                  left, rx_q.size(), W * H);
      end
      if (rx_q.size() == W * H) begin
         n_cmp++;
         if (rx_q[0].d[15:0] !== 16'h0010 || rx_q[0].d[16*4 +: 16] !== 16'h0000 ||
             rx_q[0].d[16*8 +: 16] !== 16'h0001 || rx_q[0].u !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_w0: got %h u=%b need bl=0010 mid=0000 tr=0001 u=1",
                     rx_q[0].d, rx_q[0].u);
         end
         n_cmp++;
         if (rx_q[3].l !== 1'b1 || rx_q[3].d[16*4 +: 16] !== 16'h0003 ||
             rx_q[3].d[16*5 +: 16] !== 16'h0003) begin
            n_bad++;
            $display("FAIL basic_w3: got %h l=%b need mid=0003 mr=0003 l=1",
                     rx_q[3].d, rx_q[3].l);
         end
         n_cmp++;
         if (rx_q[11].d[16*1 +: 16] !== 16'h0023) begin
            n_bad++;
            $display("FAIL basic_w11: bot_mid %h need 0023", rx_q[11].d[16*1 +: 16]);
         end
      end
      for (int i = 0; exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         g = (rx_q.size() > 0) ? rx_q.pop_front() : '0;
         n_cmp++;
         if (g !== e) begin
            n_bad++;
            $display("FAIL basic_win %0d: got %h/%b/%b need %h/%b/%b",
                     i, g.d, g.u, g.l, e.d, e.u, e.l);
         end
      end
      n_cmp++;
      if (err !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_err: got %b need 0", err);
      end
   endtask

   task automatic test_backpressure();
      int left;
      win_t g, e;
      make_frame(0);
      queue_pixels(W * H);
      queue_exp_all();
      rx_q.delete();
      stall_bad = 0;
      toggle = 1'b1;
      play(400, left);
      wait_rx(W * H);
      toggle = 1'b0;
      m_ready = 1'b1;
      tick();
      n_cmp++;
      if (left != 0 || rx_q.size() != W * H) begin
         n_bad++;
         $display("FAIL bp_count: left %0d got %0d windows need 0/%0d",
                  left, rx_q.size(), W * H);
      end
      n_cmp++;
      if (stall_bad != 0) begin
         n_bad++;
         $display("FAIL bp_stable: %0d unstable stall cycles need 0", stall_bad);
      end
      for (int i = 0; exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         g = (rx_q.size() > 0) ? rx_q.pop_front() : '0;
         n_cmp++;
         if (g !== e) begin
            n_bad++;
            $display("FAIL bp_win %0d: got %h/%b/%b need %h/%b/%b",
                     i, g.d, g.u, g.l, e.d, e.u, e.l);
         end
      end
   endtask

   task automatic test_back_to_back();
      int left, nu;
      win_t g, e;
      rx_q.delete();
      for (int f = 0; f < 2; f++) begin
         make_frame(1);
         queue_pixels(W * H);
         queue_exp_all();
      end
      rdy_low = 0;
      cnt_en = 1'b1;
      play(400, left);
      wait_rx(2 * W * H);
      cnt_en = 1'b0;
      n_cmp++;
      if (left != 0 || rx_q.size() != 2 * W * H) begin
         n_bad++;
         $display("FAIL b2b_count: left %0d got %0d windows need 0/%0d",
                  left, rx_q.size(), 2 * W * H);
      end
      n_cmp++;
      if (rdy_low != 2 * (H + W + 1)) begin
         n_bad++;
         $display("FAIL b2b_rdy_low: got %0d cycles need %0d",
                  rdy_low, 2 * (H + W + 1));
      end
      nu = 0;
      foreach (rx_q[i]) if (rx_q[i].u) nu++;
      n_cmp++;
      if (nu != 2) begin
         n_bad++;
         $display("FAIL b2b_tuser: got %0d tuser windows need 2", nu);
      end
      for (int i = 0; exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         g = (rx_q.size() > 0) ? rx_q.pop_front() : '0;
         n_cmp++;
         if (g !== e) begin
            n_bad++;
            $display("FAIL b2b_win %0d: got %h/%b/%b need %h/%b/%b",
                     i, g.d, g.u, g.l, e.d, e.u, e.l);
         end
      end
   endtask

   task automatic test_abort();
      int left, ax;
      logic exp_err;
      win_t g, e;
      ax = 2;
      rx_q.delete();
      make_frame(1);
      queue_pixels(W + ax);
      // row-0 windows whose right-hand column of row 1 was delivered
      for (int c = 0; c + 1 < ax; c++) exp_q.push_back(ref_win(0, c));
      make_frame(1);
      queue_pixels(W * H);
      queue_exp_all();
`ifdef AXIS_WIN3X3_GEOM_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      play(400, left);
      wait_rx(ax - 1 + W * H);
      n_cmp++;
      if (left != 0 || rx_q.size() != ax - 1 + W * H) begin
         n_bad++;
         $display("FAIL abort_count: left %0d got %0d windows need 0/%0d",
                  left, rx_q.size(), ax - 1 + W * H);
      end
      n_cmp++;
      if (err !== exp_err) begin
         n_bad++;
         $display("FAIL abort_err: got %b need %b", err, exp_err);
      end
      for (int i = 0; exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         g = (rx_q.size() > 0) ? rx_q.pop_front() : '0;
         n_cmp++;
         if (g !== e) begin
            n_bad++;
            $display("FAIL abort_win %0d: got %h/%b/%b need %h/%b/%b",
                     i, g.d, g.u, g.l, e.d, e.u, e.l);
         end
      end
   endtask

   task automatic test_reset_mid();
      int left;
      win_t g, e;
      make_frame(1);
      queue_pixels(2 * W + 2);
      play(200, left);
      repeat (2) tick();
      rst_n = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (m_valid !== 1'b0 || m_user !== 1'b0 || m_last !== 1'b0 ||
          m_data !== '0 || s_ready !== 1'b0 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL midrst_outs: v%b u%b l%b rdy%b err%b d=%h need all 0",
                  m_valid, m_user, m_last, s_ready, err, m_data);
      end
      tick();
      rst_n = 1'b1;
      rx_q.delete();
      exp_q.delete();
      repeat (2) tick();
      make_frame(1);
      queue_pixels(W * H);
      queue_exp_all();
      play(200, left);
      wait_rx(W * H);
      n_cmp++;
      if (left != 0 || rx_q.size() != W * H) begin
         n_bad++;
         $display("FAIL midrst_count: left %0d got %0d windows need 0/%0d",
                  left, rx_q.size(), W * H);
      end
      for (int i = 0; exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         g = (rx_q.size() > 0) ? rx_q.pop_front() : '0;
         n_cmp++;
         if (g !== e) begin
            n_bad++;
            $display("FAIL midrst_win %0d: got %h/%b/%b need %h/%b/%b",
                     i, g.d, g.u, g.l, e.d, e.u, e.l);
         end
      end
   endtask

   task automatic test_bad_flag();
      int left;
      win_t g, e;
      make_frame(2);
      queue_pixels(W * H);
      queue_exp_all();
      rx_q.delete();
      play(200, left);
      wait_rx(W * H);
      n_cmp++;
      if (rx_q.size() != W * H) begin
         n_bad++;
         $display("FAIL flag_count: got %0d windows need %0d", rx_q.size(), W * H);
      end else begin
         n_cmp++;
         if (rx_q[0].d[16*4 +: 16] !== 16'h8000 || rx_q[5].d[16*4 +: 16] !== 16'h8011) begin
            n_bad++;
            $display("FAIL flag_mid: got %h/%h need 8000/8011",
                     rx_q[0].d[16*4 +: 16], rx_q[5].d[16*4 +: 16]);
         end
      end
      for (int i = 0; exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         g = (rx_q.size() > 0) ? rx_q.pop_front() : '0;
         n_cmp++;
         if (g !== e) begin
            n_bad++;
            $display("FAIL flag_win %0d: got %h/%b/%b need %h/%b/%b",
                     i, g.d, g.u, g.l, e.d, e.u, e.l);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      test_bad_flag();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
